// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the two-port PSRAM arbiter.
// Command record widths match the default bridge geometry (25-bit word address, 32-bit data).
package psram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam int NUM_PORTS   = 2;
   localparam int DEF_TIMEOUT = 1023;
   localparam int CMD_ADDR_W  = 25;
   localparam int CMD_DATA_W  = 32;

   localparam logic [31:0] ABORT_PATTERN = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [CMD_ADDR_W-1:0] addr;
      logic [3:0]            be_n;
      logic [CMD_DATA_W-1:0] data;
      logic                  is_write;
      logic                  port;
   } cmd_t;

   localparam cmd_t CMD_RESET = '{addr: '0, be_n: 4'hF, data: '0, is_write: 1'b0, port: 1'b0};

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_arb2
   import psram_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 rr_last,
   output logic                 grant_valid,
   output logic                 grant_id
);

   always_comb begin
      grant_valid = |req;
      grant_id    = 1'b0;
      case (req)
         2'b01:   grant_id = 1'b0;
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~rr_last;
         default: grant_id = 1'b0;
      endcase
   end

endmodule

// File: rtl/psram_arbiter.sv
// Shares one psramcon bridge between two requesters: one command in flight,
// single-cycle issue strobe, completion tracking, read-data routing and a watchdog.
module psram_arbiter
   import psram_arb_pkg::*;
#(
   parameter int ADDR_W  = CMD_ADDR_W,
   parameter int DATA_W  = CMD_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [3:0]        m0_be_n,
   input  logic [DATA_W-1:0] m0_data,
   input  logic              m0_rd_n,
   input  logic              m0_wr_n,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_rvalid,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [3:0]        m1_be_n,
   input  logic [DATA_W-1:0] m1_data,
   input  logic              m1_rd_n,
   input  logic              m1_wr_n,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_rvalid,
   output logic [ADDR_W-1:0] s_addr,
   output logic [3:0]        s_be_n,
   output logic [DATA_W-1:0] s_data,
   output logic              s_cs,
   output logic              s_rd_n,
   output logic              s_wr_n,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_valid,
   input  logic              s_waitrequest,
   output logic              err_timeout,
   output logic              grant_id
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t             state_reg, state_next;
   cmd_t               cmd_reg, cmd_next;
   logic               rr_last_reg, rr_last_next;
   logic [CNT_W-1:0]   wd_reg, wd_next;
   logic               err_reg, err_next;

   logic [ADDR_W-1:0]  addr_in [NUM_PORTS];
   logic [3:0]         be_n_in [NUM_PORTS];
   logic [DATA_W-1:0]  data_in [NUM_PORTS];
   logic               wr_n_in [NUM_PORTS];
   logic [NUM_PORTS-1:0] req;
   logic [NUM_PORTS-1:0] wait_vec;
   logic               rvalid_reg [NUM_PORTS];
   logic [DATA_W-1:0]  rdata_reg  [NUM_PORTS];

   logic               grant_valid, arb_grant, accept;
   logic               in_wait, done, abort, rsp_fire;
   logic [DATA_W-1:0]  rsp_data;

   assign addr_in[0] = m0_addr;
   assign addr_in[1] = m1_addr;
   assign be_n_in[0] = m0_be_n;
   assign be_n_in[1] = m1_be_n;
   assign data_in[0] = m0_data;
   assign data_in[1] = m1_data;
   assign wr_n_in[0] = m0_wr_n;
   assign wr_n_in[1] = m1_wr_n;
   assign req[0]     = !m0_rd_n || !m0_wr_n;
   assign req[1]     = !m1_rd_n || !m1_wr_n;

   rr_arb2 u_rr_arb2 (
      .req         (req),
      .rr_last     (rr_last_reg),
      .grant_valid (grant_valid),
      .grant_id    (arb_grant)
   );

   assign accept   = (state_reg == ST_IDLE) && grant_valid;
   assign in_wait  = (state_reg == ST_WAIT);
   assign done     = in_wait && !s_waitrequest;
   // Completion takes priority over the watchdog if both land in the same cycle.
   assign abort    = in_wait && s_waitrequest && (wd_reg == CNT_W'(TIMEOUT - 1));
   assign rsp_fire = !cmd_reg.is_write && (done || abort);
   assign rsp_data = done ? (s_valid ? s_rdata : '0) : DATA_W'(ABORT_PATTERN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         cmd_reg     <= CMD_RESET;
         rr_last_reg <= 1'b1;
         wd_reg      <= '0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cmd_reg     <= cmd_next;
         rr_last_reg <= rr_last_next;
         wd_reg      <= wd_next;
         err_reg     <= err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cmd_next     = cmd_reg;
      rr_last_next = rr_last_reg;
      wd_next      = wd_reg;
      err_next     = err_reg;
      case (state_reg)
         ST_IDLE: begin
            if (grant_valid) begin
               cmd_next.addr     = CMD_ADDR_W'(addr_in[arb_grant]);
               cmd_next.be_n     = be_n_in[arb_grant];
               cmd_next.data     = CMD_DATA_W'(data_in[arb_grant]);
               cmd_next.is_write = !wr_n_in[arb_grant];
               cmd_next.port     = arb_grant;
               rr_last_next      = arb_grant;
               state_next        = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            wd_next    = '0;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (!s_waitrequest) begin
               state_next = ST_IDLE;
            end else if (abort) begin
               err_next   = 1'b1;
               state_next = ST_IDLE;
            end else begin
               wd_next = wd_reg + 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               rvalid_reg[gi] <= 1'b0;
               rdata_reg[gi]  <= '0;
            end else begin
               rvalid_reg[gi] <= rsp_fire && (cmd_reg.port == 1'(gi));
               if (rsp_fire && (cmd_reg.port == 1'(gi)))
                  rdata_reg[gi] <= rsp_data;
            end
         end
         // Reset is folded in so a held request cannot show acceptance while in reset.
         assign wait_vec[gi] = !(accept && (arb_grant == 1'(gi)) && !reset);
      end
   endgenerate

   assign m0_waitrequest = wait_vec[0];
   assign m1_waitrequest = wait_vec[1];
   assign m0_rvalid      = rvalid_reg[0];
   assign m1_rvalid      = rvalid_reg[1];
   assign m0_rdata       = rdata_reg[0];
   assign m1_rdata       = rdata_reg[1];

   assign s_cs        = (state_reg == ST_ISSUE);
   assign s_rd_n      = !((state_reg == ST_ISSUE) && !cmd_reg.is_write);
   assign s_wr_n      = !((state_reg == ST_ISSUE) && cmd_reg.is_write);
   assign s_addr      = ADDR_W'(cmd_reg.addr);
   assign s_be_n      = cmd_reg.be_n;
   assign s_data      = DATA_W'(cmd_reg.data);
   assign err_timeout = err_reg;
   assign grant_id    = cmd_reg.port;

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter: directed requests push expected issue and
// read-return records; a negedge monitor pops and compares them.
module tb_psram_arbiter;
   import psram_arb_pkg::*;

   localparam int AW  = 25;
   localparam int DW  = 32;
   localparam int TO  = 16;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [AW-1:0] m_addr [2];
   logic [3:0]    m_be_n [2];
   logic [DW-1:0] m_data [2];
   logic          m_rd_n [2];
   logic          m_wr_n [2];

   logic          m0_waitrequest, m1_waitrequest, m0_rvalid, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [AW-1:0] s_addr;
   logic [3:0]    s_be_n;
   logic [DW-1:0] s_data, s_rdata;
   logic          s_cs, s_rd_n, s_wr_n, s_valid, s_waitrequest;
   logic          err_timeout, grant_id;

   psram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .m0_addr(m_addr[0]), .m0_be_n(m_be_n[0]), .m0_data(m_data[0]),
      .m0_rd_n(m_rd_n[0]), .m0_wr_n(m_wr_n[0]),
      .m0_waitrequest(m0_waitrequest), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
      .m1_addr(m_addr[1]), .m1_be_n(m_be_n[1]), .m1_data(m_data[1]),
      .m1_rd_n(m_rd_n[1]), .m1_wr_n(m_wr_n[1]),
      .m1_waitrequest(m1_waitrequest), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
      .s_addr(s_addr), .s_be_n(s_be_n), .s_data(s_data),
      .s_cs(s_cs), .s_rd_n(s_rd_n), .s_wr_n(s_wr_n),
      .s_rdata(s_rdata), .s_valid(s_valid), .s_waitrequest(s_waitrequest),
      .err_timeout(err_timeout), .grant_id(grant_id)
   );

   // Controller model: busy for LAT+1 cycles after the strobe, read data from a small ROM.
   logic [DW-1:0] mem [16];
   logic          busy, hang, drop_valid, mdl_rd;
   logic [AW-1:0] mdl_addr;
   int            mdl_cnt;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= 1'b0; s_waitrequest <= 1'b0; s_valid <= 1'b0; s_rdata <= '0;
         mdl_cnt <= 0; mdl_rd <= 1'b0; mdl_addr <= '0;
      end else begin
         s_valid <= 1'b0;
         if (!busy) begin
            if (s_cs && (!s_rd_n || !s_wr_n)) begin
               busy <= 1'b1; s_waitrequest <= 1'b1; mdl_cnt <= LAT;
               mdl_rd <= s_wr_n; mdl_addr <= s_addr;
            end
         end else if (!hang) begin
            if (mdl_cnt == 0) begin
               busy <= 1'b0; s_waitrequest <= 1'b0;
               if (mdl_rd && !drop_valid) begin
                  s_valid <= 1'b1;
                  s_rdata <= mem[mdl_addr[3:0]];
               end
            end else begin
               mdl_cnt <= mdl_cnt - 1;
            end
         end
      end
   end

   typedef struct {
      logic          port;
      logic [AW-1:0] addr;
      logic [3:0]    be_n;
      logic [DW-1:0] data;
      logic          wr;
   } iss_t;
   typedef struct {
      logic          port;
      logic [DW-1:0] data;
      logic          chk_lat;
   } rsp_t;

   iss_t iss_q[$];
   rsp_t rsp_q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fall_cyc = 0, svalid_cyc = 0, iss_cyc = 0, rv_cyc = 0;
   int acc_cnt [2] = '{0, 0};
   int acc_cyc [2] = '{0, 0};
   logic swr_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      errors++;
      $display("FAIL %s bound expired (cycle %0d)", name, cyc);
   endtask

   // Monitor: one line per observed transaction.
   always @(negedge clk) begin
      iss_t e;
      rsp_t r;
      logic rv [2];
      logic [DW-1:0] rd [2];
      if (!reset) begin
         if (!s_waitrequest && swr_prev) fall_cyc = cyc;
         swr_prev = s_waitrequest;
         if (s_valid) svalid_cyc = cyc;
         if (!m0_waitrequest) begin acc_cnt[0]++; acc_cyc[0] = cyc; end
         if (!m1_waitrequest) begin acc_cnt[1]++; acc_cyc[1] = cyc; end
         if (s_cs) begin
            iss_cyc = cyc;
            $display("cyc %0d ISSUE port=%0d addr=%h be_n=%h data=%h rd_n=%b wr_n=%b",
                     cyc, grant_id, s_addr, s_be_n, s_data, s_rd_n, s_wr_n);
            if (iss_q.size() == 0) begin
               fail_bound("issue_unexpected");
            end else begin
               e = iss_q.pop_front();
               chk("iss_grant", grant_id, e.port);
               chk("iss_addr", s_addr, e.addr);
               chk("iss_be_n", s_be_n, e.be_n);
               chk("iss_data", s_data, e.data);
               chk("iss_wr_n", s_wr_n, !e.wr);
               chk("iss_rd_n", s_rd_n, e.wr);
            end
         end
         rv[0] = m0_rvalid; rv[1] = m1_rvalid;
         rd[0] = m0_rdata;  rd[1] = m1_rdata;
         for (int k = 0; k < 2; k++) begin
            if (rv[k]) begin
               rv_cyc = cyc;
               $display("cyc %0d RDATA port=%0d data=%h", cyc, k, rd[k]);
               if (rsp_q.size() == 0) begin
                  fail_bound("rvalid_unexpected");
               end else begin
                  r = rsp_q.pop_front();
                  chk("rsp_port", k, r.port);
                  chk("rsp_data", rd[k], r.data);
                  if (r.chk_lat) chk("rsp_latency", cyc, svalid_cyc + 1);
               end
            end
         end
      end
   end

   task automatic drive(input int p, input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [DW-1:0] d, input logic last);
      int n;
      m_addr[p] = a; m_be_n[p] = be; m_data[p] = d;
      m_rd_n[p] = !rd; m_wr_n[p] = !wr;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (!(p == 1 ? m1_waitrequest : m0_waitrequest)) break;
      end
      if (n == 200) fail_bound("accept_wait");
      @(posedge clk);
      #1;
      if (last) begin
         m_rd_n[p] = 1'b1; m_wr_n[p] = 1'b1;
      end
   endtask

   task automatic drain(input logic need_idle);
      int n;
      for (n = 0; n < 300; n++) begin
         @(posedge clk);
         if (iss_q.size() == 0 && rsp_q.size() == 0 && (!need_idle || !busy)) break;
      end
      if (n == 300) fail_bound("drain");
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         m_addr[p] = '0; m_be_n[p] = 4'hF; m_data[p] = '0; m_rd_n[p] = 1'b1; m_wr_n[p] = 1'b1;
      end
      for (int i = 0; i < 16; i++) mem[i] = 32'h0F0F_0000 + i;
      mem[0] = 32'h1234_5678; mem[1] = 32'hA0A0_0001; mem[2] = 32'hB1B1_0002;
      mem[3] = 32'hA0A0_0003; mem[4] = 32'hB1B1_0004; mem[6] = 32'h0606_0606;
      mem[7] = 32'h0707_0707; mem[8] = 32'h0808_0808;
      hang = 1'b0; drop_valid = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_cs", s_cs, 0);            chk("rst_s_rd_n", s_rd_n, 1);
      chk("rst_s_wr_n", s_wr_n, 1);        chk("rst_s_addr", s_addr, 0);
      chk("rst_s_data", s_data, 0);        chk("rst_s_be_n", s_be_n, 4'hF);
      chk("rst_m0_wait", m0_waitrequest, 1); chk("rst_m1_wait", m1_waitrequest, 1);
      chk("rst_m0_rvalid", m0_rvalid, 0);  chk("rst_m1_rvalid", m1_rvalid, 0);
      chk("rst_m0_rdata", m0_rdata, 0);    chk("rst_err", err_timeout, 0);
      chk("rst_grant", grant_id, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Single read, port 0
      iss_q.push_back('{1'b0, 25'h10, 4'h0, 32'h0, 1'b0});
      rsp_q.push_back('{1'b0, 32'h1234_5678, 1'b1});
      drive(0, 1'b1, 1'b0, 25'h10, 4'h0, 32'h0, 1'b1);
      drain(1'b1);

      // Write on port 1, then its next read is accepted right after s_waitrequest falls
      iss_q.push_back('{1'b1, 25'hFF, 4'b1100, 32'hCAFE_BABE, 1'b1});
      iss_q.push_back('{1'b1, 25'h08, 4'h0, 32'h0, 1'b0});
      rsp_q.push_back('{1'b1, 32'h0808_0808, 1'b1});
      drive(1, 1'b0, 1'b1, 25'hFF, 4'b1100, 32'hCAFE_BABE, 1'b0);
      drive(1, 1'b1, 1'b0, 25'h08, 4'h0, 32'h0, 1'b1);
      chk("b2b_accept", acc_cyc[1], fall_cyc + 1);
      drain(1'b1);

      // Tie: both ports read continuously, grants alternate 0,1,0,1
      iss_q.push_back('{1'b0, 25'h21, 4'h0, 32'h0, 1'b0});
      iss_q.push_back('{1'b1, 25'h32, 4'h0, 32'h0, 1'b0});
      iss_q.push_back('{1'b0, 25'h23, 4'h0, 32'h0, 1'b0});
      iss_q.push_back('{1'b1, 25'h34, 4'h0, 32'h0, 1'b0});
      rsp_q.push_back('{1'b0, 32'hA0A0_0001, 1'b1});
      rsp_q.push_back('{1'b1, 32'hB1B1_0002, 1'b1});
      rsp_q.push_back('{1'b0, 32'hA0A0_0003, 1'b1});
      rsp_q.push_back('{1'b1, 32'hB1B1_0004, 1'b1});
      fork
         begin
            drive(0, 1'b1, 1'b0, 25'h21, 4'h0, 32'h0, 1'b0);
            drive(0, 1'b1, 1'b0, 25'h23, 4'h0, 32'h0, 1'b1);
         end
         begin
            drive(1, 1'b1, 1'b0, 25'h32, 4'h0, 32'h0, 1'b0);
            drive(1, 1'b1, 1'b0, 25'h34, 4'h0, 32'h0, 1'b1);
         end
      join
      drain(1'b1);

      // rd_n and wr_n both low: a write
      iss_q.push_back('{1'b0, 25'h0A, 4'h3, 32'h5555_AAAA, 1'b1});
      drive(0, 1'b1, 1'b1, 25'h0A, 4'h3, 32'h5555_AAAA, 1'b1);
      drain(1'b1);

      // Read completing without s_valid returns zero
      drop_valid = 1'b1;
      iss_q.push_back('{1'b0, 25'h05, 4'h0, 32'h0, 1'b0});
      rsp_q.push_back('{1'b0, 32'h0, 1'b0});
      drive(0, 1'b1, 1'b0, 25'h05, 4'h0, 32'h0, 1'b1);
      drain(1'b1);
      drop_valid = 1'b0;

      // Watchdog on a stuck port-1 read
      hang = 1'b1;
      chk("wd_err_before", err_timeout, 0);
      iss_q.push_back('{1'b1, 25'h0C, 4'h0, 32'h0, 1'b0});
      rsp_q.push_back('{1'b1, 32'hDEAD_BEEF, 1'b0});
      drive(1, 1'b1, 1'b0, 25'h0C, 4'h0, 32'h0, 1'b1);
      drain(1'b0);
      chk("wd_latency", rv_cyc - iss_cyc, TO + 1);
      chk("wd_err", err_timeout, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("wd_err_sticky", err_timeout, 1);

      // Async reset in the middle of WAIT (controller still stuck)
      iss_q.push_back('{1'b0, 25'h06, 4'h0, 32'h0, 1'b0});
      drive(0, 1'b1, 1'b0, 25'h06, 4'h0, 32'h0, 1'b1);
      repeat (4) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("mid_rst_s_cs", s_cs, 0);       chk("mid_rst_s_rd_n", s_rd_n, 1);
      chk("mid_rst_s_addr", s_addr, 0);   chk("mid_rst_s_be_n", s_be_n, 4'hF);
      chk("mid_rst_err", err_timeout, 0); chk("mid_rst_m1_rdata", m1_rdata, 0);
      m_rd_n[0] = 1'b0; m_rd_n[1] = 1'b0;
      #1;
      chk("mid_rst_m0_wait", m0_waitrequest, 1);
      chk("mid_rst_m1_wait", m1_waitrequest, 1);
      m_rd_n[0] = 1'b1; m_rd_n[1] = 1'b1;
      hang = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      iss_q.push_back('{1'b0, 25'h06, 4'h0, 32'h0, 1'b0});
      iss_q.push_back('{1'b1, 25'h07, 4'h0, 32'h0, 1'b0});
      rsp_q.push_back('{1'b0, 32'h0606_0606, 1'b1});
      rsp_q.push_back('{1'b1, 32'h0707_0707, 1'b1});
      fork
         drive(0, 1'b1, 1'b0, 25'h06, 4'h0, 32'h0, 1'b1);
         drive(1, 1'b1, 1'b0, 25'h07, 4'h0, 32'h0, 1'b1);
      join
      drain(1'b1);

      chk("accepts_port0", acc_cnt[0], 7);
      chk("accepts_port1", acc_cnt[1], 6);
      chk("iss_q_empty", iss_q.size(), 0);
      chk("rsp_q_empty", rsp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout reached (cycle %0d)", cyc);
      $fatal(1, "simulation time limit");
   end

endmodule
